// File: rtl/bcd_to_binary_10_bits_pkg.sv
// bcd_to_binary_10_bits_pkg: shared constants and state encoding for the BCD-to-binary converter
package bcd_to_binary_10_bits_pkg;
   localparam int BIN_W     = 10;
   localparam int DIGITS    = 4;
   localparam int DIGIT_W   = 4;
   localparam int BCD_W     = DIGITS * DIGIT_W;
   localparam int MAX_VALUE = 1023;
   localparam logic [DIGIT_W-1:0] MAX_THOUSANDS = 4'd1;
   localparam logic [3*DIGIT_W-1:0] MAX_LOWER_BCD = 12'h023;
   localparam logic [3:0] LAST_STEP = 4'(BIN_W - 1);
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      DONE    = 2'd2
   } state_t;
endpackage

// File: rtl/bcd_to_binary_10_bits_adjust.sv
// bcd_digit_adjust: one reverse double-dabble digit correction, subtract 3 from digits >= 8
module bcd_digit_adjust (
   input  logic [3:0] din,
   output logic [3:0] dout
);
   assign dout = (din >= 4'd8) ? din - 4'd3 : din;
endmodule

// File: rtl/bcd_to_binary_10_bits.sv
// bcd_to_binary_10_bits: iterative reverse double-dabble converter from 4 packed BCD digits to 10-bit binary
module bcd_to_binary_10_bits
   import bcd_to_binary_10_bits_pkg::*;
(
   input  logic        CLOCK_50,
   input  logic        Resetn,
   input  logic [15:0] bcd_in,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [9:0]  bin_out
);
   state_t             state;
   logic [BCD_W-1:0]   digits;
   logic [BIN_W-1:0]   result;
   logic [3:0]         cnt;
   logic [BCD_W-1:0]   sh_dig;
   logic [BCD_W-1:0]   adj_dig;
   logic [BIN_W-1:0]   sh_res;
   logic               illegal;

   assign sh_dig = {1'b0, digits[BCD_W-1:1]};
   assign sh_res = {digits[0], result[BIN_W-1:1]};

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adjust u_adj (
         .din  (sh_dig[DIGIT_W*g +: DIGIT_W]),
         .dout (adj_dig[DIGIT_W*g +: DIGIT_W])
      );
   end

   // flag non-decimal digits and values above the 10-bit range
   always_comb begin
      illegal = 1'b0;
      for (int i = 0; i < DIGITS; i++)
         if (bcd_in[DIGIT_W*i +: DIGIT_W] > 4'd9) illegal = 1'b1;
      if (bcd_in[15:12] > MAX_THOUSANDS) illegal = 1'b1;
      if (bcd_in[15:12] == MAX_THOUSANDS && bcd_in[11:0] > MAX_LOWER_BCD) illegal = 1'b1;
   end

   // control FSM and datapath with registered outputs
   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
         state   <= IDLE;
         digits  <= '0;
         result  <= '0;
         cnt     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         error   <= 1'b0;
         bin_out <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start && illegal) begin
                  state   <= DONE;
                  done    <= 1'b1;
                  error   <= 1'b1;
                  bin_out <= '0;
               end else if (start) begin
                  state  <= CONVERT;
                  digits <= bcd_in;
                  result <= '0;
                  cnt    <= '0;
                  error  <= 1'b0;
                  busy   <= 1'b1;
               end
            end
            CONVERT: begin
               digits <= adj_dig;
               result <= sh_res;
               cnt    <= cnt + 4'd1;
               if (cnt == LAST_STEP) begin
                  state   <= DONE;
                  bin_out <= sh_res;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bcd_to_binary_10_bits.sv
// tb_bcd_to_binary_10_bits: scoreboard bench for the BCD-to-binary converter
module tb_bcd_to_binary_10_bits;
   import bcd_to_binary_10_bits_pkg::*;

   typedef struct {
      logic       err;
      logic [9:0] bin;
   } exp_t;

   logic        CLOCK_50 = 1'b0;
   logic        Resetn;
   logic [15:0] bcd_in;
   logic        start;
   logic        busy, done, error;
   logic [9:0]  bin_out;
   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_bad = 0;

   bcd_to_binary_10_bits dut (
      .CLOCK_50 (CLOCK_50),
      .Resetn   (Resetn),
      .bcd_in   (bcd_in),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .error    (error),
      .bin_out  (bin_out)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [15:0] b);
      exp_t e;
      int   v;
      logic bad_digit;
      bad_digit = 1'b0;
      v = 0;
      for (int i = 3; i >= 0; i--) begin
         if (b[4*i +: 4] > 4'd9) bad_digit = 1'b1;
         v = v * 10 + int'(b[4*i +: 4]);
      end
      e.err = bad_digit || (v > MAX_VALUE);
      e.bin = e.err ? 10'd0 : 10'(v);
      return e;
   endfunction

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic run(input logic [15:0] b, input int poke);
      int   lat;
      int   bcnt;
      exp_t e;
      exp_t m;
      m = model(b);
      @(negedge CLOCK_50);
      bcd_in = b;
      start  = 1'b1;
      sb.push_back(m);
      lat  = 0;
      bcnt = 0;
      do begin
         @(negedge CLOCK_50);
         lat++;
         if (lat == 1 || lat == poke + 1) start = 1'b0;
         if (lat == poke) begin
            bcd_in = 16'h0001;
            start  = 1'b1;
         end
         if (busy) bcnt++;
      end while (!done && lat < 30);
      check("latency", lat, m.err ? 1 : 11);
      check("busy_cycles", bcnt, m.err ? 0 : 10);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("bin_out", bin_out, e.bin);
         check("error", error, e.err);
         if (!e.err) check("digits_zero", dut.digits, 0);
      end
      @(negedge CLOCK_50);
      check("done_pulse", done, 0);
      check("held_bin", bin_out, m.bin);
   endtask

   initial begin
      int bad;
      Resetn = 1'b0;
      start  = 1'b0;
      bcd_in = 16'h0000;
      repeat (3) @(negedge CLOCK_50);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_bin", bin_out, 0);
      Resetn = 1'b1;
      run(16'h0000, 0);
      run(16'h1023, 0);
      run(16'h0999, 0);
      run(16'h0512, 0);
      run(16'h1024, 0);
      run(16'h00A5, 0);
      run(16'h0042, 0);
      run(16'h2000, 0);
      run(16'h1030, 0);
      run(16'h0777, 4);
      for (int i = 0; i < 6; i++) run(to_bcd(int'($urandom_range(0, 1023))), 0);
      @(negedge CLOCK_50);
      bcd_in = 16'h0500;
      start  = 1'b1;
      @(negedge CLOCK_50);
      start = 1'b0;
      repeat (4) @(negedge CLOCK_50);
      Resetn = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_error", error, 0);
      check("midrst_bin", bin_out, 0);
      bad = 0;
      repeat (3) begin
         @(negedge CLOCK_50);
         if (done) bad++;
      end
      Resetn = 1'b1;
      repeat (12) begin
         @(negedge CLOCK_50);
         if (done || busy) bad++;
      end
      check("no_done_after_rst", bad, 0);
      run(16'h0003, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end
endmodule
